// File: rtl/audio_pkg.sv
// Shared audio constants and types for the codec serial paths.
package audio_pkg;
  localparam int AUDIO_DATA_W = 16;
  localparam int BCLK_DIV     = 8;
  localparam int FRAME_BCLKS  = 250;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} s2p_state_t;
endpackage

// File: rtl/sync_edge.sv
// Three-flop-deep synchronizer; EDGE=1 adds a registered rising-edge strobe.
// q is taken from the third flop so plain instances stay aligned with rise.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk96M,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk96M) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q = s3;

  generate
    if (EDGE) begin : g_edge
      logic rise_q;
      always_ff @(posedge clk96M) begin
        if (reset) rise_q <= 1'b0;
        else       rise_q <= s2 & ~s3;
      end
      assign rise = rise_q;
    end else begin : g_plain
      assign rise = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/serial2para.sv
// Codec record-stream deserializer (DSP/PCM framing) into stereo samples.
// Define SERIAL2PARA_FRAMECHK_EN to get frame_err pulses on aborted frames.
module serial2para
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic              clk96M,
  input  logic              reset,
  input  logic              bclk,
  input  logic              reclrc,
  input  logic              recdat,
  output logic [DATA_W-1:0] lch,
  output logic [DATA_W-1:0] rch,
  output logic              valid,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic bedge, lrc_s, dat_s, bclk_s_unused, lrc_unused, dat_unused;

  sync_edge #(.EDGE(1'b1)) u_bclk (.clk96M, .reset, .d(bclk),   .q(bclk_s_unused), .rise(bedge));
  sync_edge #(.EDGE(1'b0)) u_lrc  (.clk96M, .reset, .d(reclrc), .q(lrc_s),         .rise(lrc_unused));
  sync_edge #(.EDGE(1'b0)) u_dat  (.clk96M, .reset, .d(recdat), .q(dat_s),         .rise(dat_unused));

  s2p_state_t        state_q, state_d;
  logic [CW-1:0]     bitcnt, cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d, hold, hold_d, lch_d, rch_d, word;
  logic              lrc_prev, start, valid_d;

  // Rising edge of reclrc as seen on bclk edges: a long pulse starts once.
  assign start = bedge & lrc_s & ~lrc_prev;
  assign word  = {shreg[DATA_W-2:0], dat_s};

  always_ff @(posedge clk96M) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bitcnt;
    shreg_d = shreg;
    hold_d  = hold;
    lch_d   = lch;
    rch_d   = rch;
    valid_d = 1'b0;
    if (bedge) begin
      if (start) begin
        // Frame start wins over everything, including the final right bit.
        state_d = LEFT;
        cnt_d   = '0;
      end else begin
        case (state_q)
          LEFT: begin
            shreg_d = word;
            if (bitcnt == LAST) begin
              hold_d  = word;
              cnt_d   = '0;
              state_d = RIGHT;
            end else begin
              cnt_d = bitcnt + 1'b1;
            end
          end
          RIGHT: begin
            shreg_d = word;
            if (bitcnt == LAST) begin
              lch_d   = hold;
              rch_d   = word;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = bitcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk96M) begin
    if (reset) begin
      bitcnt   <= '0;
      shreg    <= '0;
      hold     <= '0;
      lch      <= '0;
      rch      <= '0;
      valid    <= 1'b0;
      lrc_prev <= 1'b0;
    end else begin
      bitcnt <= cnt_d;
      shreg  <= shreg_d;
      hold   <= hold_d;
      lch    <= lch_d;
      rch    <= rch_d;
      valid  <= valid_d;
      if (bedge) lrc_prev <= lrc_s;
    end
  end

`ifdef SERIAL2PARA_FRAMECHK_EN
  logic err_q;
  always_ff @(posedge clk96M) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= start & (state_q != IDLE);
  end
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial2para.sv
// Directed bench for serial2para: frame generator, sample scoreboard, timing checks.
module tb_serial2para;
  logic clk96M = 1'b0, reset = 1'b1, bclk = 1'b0, reclrc = 1'b0, recdat = 1'b0;
  logic [15:0] lch, rch;
  logic valid, frame_err;

  serial2para #(.DATA_W(16)) dut (
    .clk96M(clk96M), .reset(reset), .bclk(bclk), .reclrc(reclrc), .recdat(recdat),
    .lch(lch), .rch(rch), .valid(valid), .frame_err(frame_err)
  );

  always #5 clk96M = ~clk96M;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, rst_cnt = 0;
  logic [31:0] sb[$];
  int vtimes[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk96M) cyc <= cyc + 1;

  // Scoreboard: every valid must match the oldest pending expected pair.
  always @(negedge clk96M) begin
    if (frame_err === 1'b1) err_cnt++;
    if (valid === 1'b1) begin
      valid_cnt++;
      vtimes.push_back(cyc);
      if (sb.size() == 0) check("unexpected_valid", {lch, rch}, 32'hxxxxxxxx);
      else check("sample", {lch, rch}, sb.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk96M);
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) reset = 1'b0;
    end
  endtask

  // One frame: lrc high for lrc_len bclks at index 0 (plus an extra pulse at
  // abort_at when >0, which becomes the data origin), L then R MSB first.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbclk,
                            input int lrc_len, input int abort_at, input int rst_at,
                            input bit push);
    int o, j;
    logic [15:0] lv, rv;
    lv = l;
    rv = r;
    o = (abort_at > 0) ? abort_at : 0;
    if (push) sb.push_back({l, r});
    for (int k = 0; k < nbclk; k++) begin
      j = k - o - 1;
      if (k == rst_at) begin
        reset = 1'b1;
        rst_cnt = 20;
      end
      bclk = 1'b0;
      reclrc = (k < lrc_len) || (abort_at > 0 && k == abort_at);
      if (abort_at > 0 && k > 0 && k < abort_at) recdat = k[0];
      else if (j >= 0 && j < 16) recdat = lv[15-j];
      else if (j >= 16 && j < 32) recdat = rv[31-j];
      else recdat = 1'b0;
      repeat (4) tick();
      bclk = 1'b1;
      repeat (4) tick();
    end
  endtask

  initial begin
    int v0, n, s;
    logic [15:0] sl;
    repeat (5) tick();
    check("rst_lch", {16'h0, lch}, 32'h0);
    check("rst_rch", {16'h0, rch}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (3) tick();

    send_frame(16'h1234, 16'hABCD, 250, 1, 0, -1, 1'b1);
    check("valid_cnt_f1", valid_cnt, 1);
    send_frame(16'h8000, 16'h7FFF, 250, 1, 0, -1, 1'b1);
    send_frame(16'hFFFF, 16'h0001, 250, 1, 0, -1, 1'b1);
    check("valid_cnt_f3", valid_cnt, 3);
    if (vtimes.size() >= 3) begin
      check("spacing_1_2", vtimes[1] - vtimes[0], 2000);
      check("spacing_2_3", vtimes[2] - vtimes[1], 2000);
    end else check("spacing_valids", vtimes.size(), 3);
    check("held_lch", {16'h0, lch}, 32'hFFFF);

    // Reset during the right word: nothing emitted, outputs cleared.
    send_frame(16'h5555, 16'h3333, 250, 1, 0, 20, 1'b0);
    check("rst_mid_valid_cnt", valid_cnt, 3);
    check("rst_mid_out", {lch, rch}, 32'h0);
    check("rst_mid_reset_low", {31'h0, reset}, 32'h0);
    send_frame(16'hA5A5, 16'h5A5A, 250, 1, 0, -1, 1'b1);
    check("post_rst_valid_cnt", valid_cnt, 4);

    // Abort after 5 left bits, restarted frame carries the data.
    send_frame(16'hC3C3, 16'h0F0F, 250, 1, 6, -1, 1'b1);
    check("abort_valid_cnt", valid_cnt, 5);
`ifdef SERIAL2PARA_FRAMECHK_EN
    check("abort_frame_err", err_cnt, 1);
`else
    check("abort_frame_err", err_cnt, 0);
`endif

    // lrc held for 3 bclks: one start, data from the first bclk after it.
    send_frame(16'h1357, 16'h2468, 250, 3, 0, -1, 1'b1);
    check("held_lrc_valid_cnt", valid_cnt, 6);

    // 440 Hz sine, shortened frames (frame length is irrelevant to decode).
    v0 = valid_cnt;
    for (n = 0; n < 100; n++) begin
      s = $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * 440.0 * n / 48000.0));
      sl = s[15:0];
      send_frame(sl, -sl, 40, 1, 0, -1, 1'b1);
    end
    repeat (20) tick();
    check("sine_valid_cnt", valid_cnt - v0, 100);
    check("sb_drained", sb.size(), 0);
`ifdef SERIAL2PARA_FRAMECHK_EN
    check("final_frame_err", err_cnt, 1);
`else
    check("final_frame_err", err_cnt, 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
